// File: rtl/rv32i_ctrl_pkg.sv
// rtl/rv32i_ctrl_pkg.sv - shared encodings for the multi-cycle RV32I control path
package rv32i_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUREG = 1'b1;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUREG = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;

    localparam logic [1:0] ALUA_PC    = 2'd0;
    localparam logic [1:0] ALUA_OLDPC = 2'd1;
    localparam logic [1:0] ALUA_RS1   = 2'd2;

    localparam logic [1:0] ALUB_RS2  = 2'd0;
    localparam logic [1:0] ALUB_IMM  = 2'd1;
    localparam logic [1:0] ALUB_FOUR = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] RES_ALUREG = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_PC4    = 2'd2;
    localparam logic [1:0] RES_IMM    = 2'd3;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    // Fences and system ops retire as no-ops straight back to FETCH.
    function automatic state_t dispatch(input logic [6:0] op);
        state_t s;
        case (op)
            OP_R:                s = S_EXEC_R;
            OP_I:                s = S_EXEC_I;
            OP_LOAD, OP_STORE:   s = S_MEM_ADDR;
            OP_BRANCH:           s = S_BRANCH;
            OP_JAL:              s = S_JAL;
            OP_JALR:             s = S_JALR;
            OP_LUI:              s = S_LUI;
            OP_AUIPC:            s = S_AUIPC;
            OP_FENCE, OP_SYSTEM: s = S_FETCH;
            default:             s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main sequencing FSM of the multi-cycle RV32I core
module multicycle_ctrl
    import rv32i_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic [1:0] alu_op,
    output logic [2:0] imm_sel,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] fault,
    output logic [3:0] state
);

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [1:0] fault_q, fault_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // funct3 is consumed by the branch comparator and load/store unit; the sequence ignores it.
    logic unused_funct3;
    assign unused_funct3 = ^funct3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            fault_q   <= FAULT_NONE;
            tmo_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        tmo_cnt_d  = tmo_cnt_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = ADR_PC;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        alu_a_sel  = ALUA_PC;
        alu_b_sel  = ALUB_RS2;
        alu_op     = ALUOP_ADD;
        imm_sel    = IMM_I;
        reg_write  = 1'b0;
        result_src = RES_ALUREG;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                adr_src   = ADR_PC;
                alu_a_sel = ALUA_PC;
                alu_b_sel = ALUB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_ALU;
                    state_d  = S_DECODE;
                end
            end
            // Branch target is computed here so BRANCH only has to compare.
            S_DECODE: begin
                alu_a_sel = ALUA_OLDPC;
                alu_b_sel = ALUB_IMM;
                imm_sel   = IMM_B;
                alu_op    = ALUOP_ADD;
                state_d   = dispatch(opcode);
                if (state_d == S_TRAP) begin
                    fault_d = FAULT_ILLEGAL;
                end
            end
            S_EXEC_R: begin
                alu_a_sel = ALUA_RS1;
                alu_b_sel = ALUB_RS2;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_a_sel = ALUA_RS1;
                alu_b_sel = ALUB_IMM;
                imm_sel   = IMM_I;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_a_sel = ALUA_RS1;
                alu_b_sel = ALUB_IMM;
                alu_op    = ALUOP_ADD;
                if (opcode == OP_STORE) begin
                    imm_sel = IMM_S;
                    state_d = S_MEM_WR;
                end else begin
                    imm_sel = IMM_I;
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                adr_src = ADR_ALUREG;
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = ADR_ALUREG;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                result_src = RES_ALUREG;
                state_d    = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_a_sel = ALUA_RS1;
                alu_b_sel = ALUB_RS2;
                alu_op    = ALUOP_SUB;
                if (br_taken) begin
                    pc_write = 1'b1;
                    pc_src   = PC_ALUREG;
                end
                state_d = S_FETCH;
            end
            S_JAL: begin
                alu_a_sel  = ALUA_OLDPC;
                alu_b_sel  = ALUB_IMM;
                imm_sel    = IMM_J;
                alu_op     = ALUOP_ADD;
                pc_write   = 1'b1;
                pc_src     = PC_ALU;
                reg_write  = 1'b1;
                result_src = RES_PC4;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                alu_a_sel  = ALUA_RS1;
                alu_b_sel  = ALUB_IMM;
                imm_sel    = IMM_I;
                alu_op     = ALUOP_ADD;
                pc_write   = 1'b1;
                pc_src     = PC_JALR;
                reg_write  = 1'b1;
                result_src = RES_PC4;
                state_d    = S_FETCH;
            end
            S_LUI: begin
                imm_sel    = IMM_U;
                reg_write  = 1'b1;
                result_src = RES_IMM;
                state_d    = S_FETCH;
            end
            S_AUIPC: begin
                alu_a_sel = ALUA_OLDPC;
                alu_b_sel = ALUB_IMM;
                imm_sel   = IMM_U;
                alu_op    = ALUOP_ADD;
                state_d   = S_WB_ALU;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A ready in the final allowed cycle completes normally instead of faulting.
        if (mem_req && !mem_ready) begin
            if (tmo_cnt_q == TMO_LAST) begin
                state_d = S_TRAP;
                fault_d = FAULT_TIMEOUT;
            end
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
        if (state_d != state_q) begin
            tmo_cnt_d = 8'd0;
        end

        // Reset drops every request and enable immediately, without waiting for an edge.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            adr_src    = ADR_PC;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = PC_ALU;
            alu_a_sel  = ALUA_PC;
            alu_b_sel  = ALUB_RS2;
            alu_op     = ALUOP_ADD;
            imm_sel    = IMM_I;
            reg_write  = 1'b0;
            result_src = RES_ALUREG;
        end
    end

    assign fault = fault_q;
    assign state = state_q;

endmodule
